ldl_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (for example a shifter or bus port) among WIDTH requesters. Priority rotates on a ring. The pending request vector is ring-rotated right by the priority pointer, the lowest set bit is picked, and the index is mapped back. A grant is held for a whole transaction until the resource signals completion. The pointer then advances past the last winner.

---
 rtl/ldl_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_ldl_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_rr_arbiter.sv
// Round-robin arbiter: one grant held per transaction, ring-rotating priority.
// Optional watchdog release compiled in with LDL_RR_ARBITER_TIMEOUT_EN.
module ldl_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [WIDTH-1:0]                       req,
    input  logic                                   done,
    output logic [WIDTH-1:0]                       grant,
    output logic [((WIDTH>1)?$clog2(WIDTH):1)-1:0] grant_idx,
    output logic                                   busy,
    output logic [((WIDTH>1)?$clog2(WIDTH):1)-1:0] ptr,
    output logic                                   timeout
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("ldl_rr_arbiter: WIDTH and TIMEOUT must be >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    ptr_nx;
    logic [IW-1:0]    pick_cur;
    logic [IW-1:0]    pick_nx;
    logic             rel;
    logic             hit;

    // First requester in ring order starting at p (modulo WIDTH).
    function automatic logic [IW-1:0] sel(input logic [WIDTH-1:0] r,
                                          input logic [IW-1:0]    p);
        int j;
        sel = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= WIDTH) j = j - WIDTH;
            if (r[j]) sel = IW'(j);
        end
    endfunction

    // Candidate winners for fresh and back-to-back arbitration.
    always_comb begin
        ptr_nx   = (idx_q == IW'(WIDTH - 1)) ? '0 : idx_q + IW'(1);
        pick_cur = sel(req, ptr_q);
        pick_nx  = sel(req, ptr_nx);
        rel      = (state_q == BUSY) && (done || !req[idx_q] || hit);
    end

    // Next-state and grant selection.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    idx_d   = pick_cur;
                    grant_d = WIDTH'(1) << pick_cur;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d = ptr_nx;
                    if (|req) begin
                        idx_d   = pick_nx;
                        grant_d = WIDTH'(1) << pick_nx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef LDL_RR_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // Watchdog: count held cycles, force release on the TIMEOUT-th one.
    always_comb begin
        hit   = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT - 1));
        tmo_d = hit && !done;
        cnt_d = '0;
        if (state_q == BUSY && !rel) cnt_d = cnt_q + CW'(1);
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign hit     = 1'b0;
    assign timeout = 1'b0;
`endif

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = (state_q == BUSY);
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// Bench for ldl_rr_arbiter: vector table, corner sequences, random vs model.
// Two instances: WIDTH=4 (TIMEOUT=8) and WIDTH=5 (TIMEOUT=32).
module tb_ldl_rr_arbiter;

`ifdef LDL_RR_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req4 = '0;
    logic       done4 = 1'b0;
    logic [3:0] g4;
    logic [1:0] gi4, p4;
    logic       b4, t4;
    logic [4:0] req5 = '0;
    logic       done5 = 1'b0;
    logic [4:0] g5;
    logic [2:0] gi5, p5;
    logic       b5, t5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ldl_rr_arbiter #(.WIDTH(4), .TIMEOUT(8)) u_d4 (
        .clk(clk), .rstn(rstn), .req(req4), .done(done4),
        .grant(g4), .grant_idx(gi4), .busy(b4), .ptr(p4), .timeout(t4)
    );

    ldl_rr_arbiter #(.WIDTH(5), .TIMEOUT(32)) u_d5 (
        .clk(clk), .rstn(rstn), .req(req5), .done(done5),
        .grant(g5), .grant_idx(gi5), .busy(b5), .ptr(p5), .timeout(t5)
    );

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] p;
        logic       b;
    } vec_t;

    typedef struct {
        bit busy;
        int idx;
        int ptr;
        int held;
        bit tmo;
    } mstate_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closest requester to p walking up the ring.
    function automatic int pick(input logic [7:0] r, input int p, input int w);
        int best = -1;
        int bd = w;
        for (int i = 0; i < w; i++) begin
            if (r[i] && ((i - p + w) % w) < bd) begin
                bd = (i - p + w) % w;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int w,
                                      input int tmax, input logic [7:0] r,
                                      input bit d);
        mstate_t n = s;
        bit h;
        n.tmo = 1'b0;
        if (!s.busy) begin
            if (r != 0) begin
                n.busy = 1'b1;
                n.idx  = pick(r, s.ptr, w);
                n.held = 0;
            end
        end else begin
            n.held = s.held + 1;
            h = TMO_EN && (n.held >= tmax);
            if (d || !r[s.idx] || h) begin
                n.tmo = h && !d;
                n.ptr = (s.idx + 1) % w;
                n.held = 0;
                if (r != 0) n.idx = pick(r, n.ptr, w);
                else n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic chk_m(input string nm, input mstate_t m,
                         input logic [31:0] g, input logic [31:0] gi,
                         input logic b, input logic [31:0] p, input logic t);
        chk({nm, ".grant"}, g, m.busy ? (32'd1 << m.idx) : 32'd0);
        chk({nm, ".busy"}, {31'd0, b}, {31'd0, m.busy});
        chk({nm, ".ptr"}, p, m.ptr);
        chk({nm, ".timeout"}, {31'd0, t}, {31'd0, m.tmo});
        if (m.busy) chk({nm, ".idx"}, gi, m.idx);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req4 = '0; done4 = 1'b0;
        req5 = '0; done5 = 1'b0;
        #12;
        rstn = 1'b1;
        tick();
    endtask

    vec_t    tv[12];
    mstate_t m4, m5;

    initial begin
        // ring sweep, skip of released index, abort, idle done, hold
        tv[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tv[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
        tv[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        tv[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        tv[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
        tv[5]  = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
        tv[6]  = '{4'b0011, 1'b1, 4'b0001, 2'd2, 1'b1};
        tv[7]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
        tv[8]  = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};
        tv[9]  = '{4'b0100, 1'b0, 4'b0100, 2'd1, 1'b1};
        tv[10] = '{4'b0110, 1'b0, 4'b0100, 2'd1, 1'b1};
        tv[11] = '{4'b0110, 1'b1, 4'b0010, 2'd3, 1'b1};

        #3;
        chk("rst.grant", {28'd0, g4}, 32'd0);
        chk("rst.busy", {31'd0, b4}, 32'd0);
        chk("rst.ptr", {30'd0, p4}, 32'd0);
        chk("rst.idx", {30'd0, gi4}, 32'd0);
        chk("rst.timeout", {31'd0, t4}, 32'd0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            req4 = tv[i].req;
            done4 = tv[i].done;
            tick();
            chk($sformatf("vec%0d.grant", i), {28'd0, g4}, {28'd0, tv[i].g});
            chk($sformatf("vec%0d.ptr", i), {30'd0, p4}, {30'd0, tv[i].p});
            chk($sformatf("vec%0d.busy", i), {31'd0, b4}, {31'd0, tv[i].b});
        end

        // asynchronous reset while busy, no clock edge in between
        done4 = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.grant", {28'd0, g4}, 32'd0);
        chk("arst.busy", {31'd0, b4}, 32'd0);
        chk("arst.ptr", {30'd0, p4}, 32'd0);
        #2;
        req4 = 4'b1000;
        rstn = 1'b1;
        tick();
        chk("arst.regrant", {28'd0, g4}, 32'b1000);

        // WIDTH=5 wrap-around from ptr 4
        do_reset();
        req5 = 5'b01000;
        tick();
        req5 = 5'b10001;
        done5 = 1'b1;
        tick();
        chk("w5.grant4", {27'd0, g5}, 32'b10000);
        chk("w5.ptr4", {29'd0, p5}, 32'd4);
        tick();
        chk("w5.grant0", {27'd0, g5}, 32'b00001);
        chk("w5.ptr0", {29'd0, p5}, 32'd0);

        // long hold without done, then withdraw the holder
        done5 = 1'b0;
        req5 = 5'b01110;
        tick();
        chk("hold.start", {27'd0, g5}, 32'b00010);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("hold.grant", {27'd0, g5}, 32'b00010);
        end
        req5 = 5'b01100;
        tick();
        chk("abort.grant", {27'd0, g5}, 32'b00100);
        chk("abort.ptr", {29'd0, p5}, 32'd2);

        // watchdog on the sole requester
        do_reset();
        req4 = 4'b0001;
        tick();
        chk("wd.grant", {28'd0, g4}, 32'b0001);
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("wd%0d.timeout", c), {31'd0, t4},
                {31'd0, (TMO_EN && c == 8)});
            chk($sformatf("wd%0d.grant", c), {28'd0, g4}, 32'b0001);
            chk($sformatf("wd%0d.ptr", c), {30'd0, p4},
                (TMO_EN && c >= 8) ? 32'd1 : 32'd0);
        end

        // randomized traffic against the reference model
        do_reset();
        m4 = '{1'b0, 0, 0, 0, 1'b0};
        m5 = '{1'b0, 0, 0, 0, 1'b0};
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) req4[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(3) == 0) req5[$urandom_range(4)] ^= 1'b1;
            done4 = ($urandom_range(7) == 0);
            done5 = ($urandom_range(5) == 0);
            tick();
            m4 = mstep(m4, 4, 8, {4'd0, req4}, done4);
            m5 = mstep(m5, 5, 32, {3'd0, req5}, done5);
            chk_m("rnd4", m4, {28'd0, g4}, {30'd0, gi4}, b4, {30'd0, p4}, t4);
            chk_m("rnd5", m5, {27'd0, g5}, {29'd0, gi5}, b5, {29'd0, p5}, t5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
